// File: rtl/knn_sort_pkg.sv
// Shared types and timing helpers for the k-nearest sort sequencer.
package knn_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SORT,
    ST_OUTPUT
  } sort_state_t;

  // Length of a complete odd-even transposition sort of n entries.
  // There are n passes. Each compare takes two cycles (issue, write-back).
  function automatic int sort_cycles(input int n);
    return 2 * (n / 2) * (n - 1);
  endfunction

endpackage

// File: rtl/sort_seq_ctrl_if.sv
// Load and output handshake bundle of the sort sequencer.
interface sort_seq_ctrl_if #(
  parameter int W      = 16,
  parameter int TYPE_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_dist;
  logic [TYPE_W-1:0] in_type;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_dist;
  logic [TYPE_W-1:0] out_type;
  logic              out_last;

  modport master (
    output in_valid, in_dist, in_type, out_ready,
    input  in_ready, out_valid, out_dist, out_type, out_last
  );

  modport slave (
    input  in_valid, in_dist, in_type, out_ready,
    output in_ready, out_valid, out_dist, out_type, out_last
  );
endinterface

// File: rtl/sort_seq_ctrl_cmp_swap.sv
// Combinational compare-swap of two (dist,type) pairs.
// Equal distances keep their order.
module cmp_swap #(
  parameter int W      = 16,
  parameter int TYPE_W = 3
) (
  input  logic              ascending,
  input  logic [W-1:0]      a_dist,
  input  logic [TYPE_W-1:0] a_type,
  input  logic [W-1:0]      b_dist,
  input  logic [TYPE_W-1:0] b_type,
  output logic [W-1:0]      first_dist,
  output logic [TYPE_W-1:0] first_type,
  output logic [W-1:0]      second_dist,
  output logic [TYPE_W-1:0] second_type
);
  logic swap;

  assign swap        = ascending ? (a_dist > b_dist) : (a_dist < b_dist);
  assign first_dist  = swap ? b_dist : a_dist;
  assign first_type  = swap ? b_type : a_type;
  assign second_dist = swap ? a_dist : b_dist;
  assign second_type = swap ? a_type : b_type;
endmodule

// File: rtl/sort_seq_ctrl.sv
// Batch sorter: loads N (dist,type) entries and sorts them with one shared compare-swap unit.
// It then streams the first K entries of the sorted batch.
//   IDLE   | waiting for the first entry of a batch
//   LOAD   | accepting the remaining entries
//   SORT   | issue / write-back of compare pairs until the sort timer expires
//   OUTPUT | presenting entries 0..K-1 downstream
module sort_seq_ctrl
  import knn_sort_pkg::*;
#(
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int N      = 8,
  parameter int K      = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ascending,
  output logic           busy,
  sort_seq_ctrl_if.slave bus
);
  localparam int CW       = $clog2(N + 1);
  localparam int AW       = $clog2(N);
  localparam int SORT_CYC = sort_cycles(N);
  localparam int TW       = $clog2(SORT_CYC + 1);
  localparam logic [CW-1:0] LAST_LOAD   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_OUT    = CW'(K - 1);
  localparam logic [CW-1:0] LAST_PAIR_E = CW'(N / 2 - 1);
  localparam logic [CW-1:0] LAST_PAIR_O = (N > 2) ? CW'(N / 2 - 2) : '0;

  if ((N < 2) || (N % 2 != 0)) begin : g_bad_n
    $error("sort_seq_ctrl: N must be even and at least 2");
  end
  if ((K < 1) || (K > N)) begin : g_bad_k
    $error("sort_seq_ctrl: K must lie in 1..N");
  end

  sort_state_t       state, state_nx;
  logic [CW-1:0]     load_idx, out_idx, pass, pair;
  logic [TW-1:0]     sort_tmr;
  logic              phase;
  logic              asc_q;
  logic              in_fire, out_fire, last_load, last_pair, sort_done;
  logic [AW-1:0]     left_idx, right_idx;
  logic [W-1:0]      dist_buf [N];
  logic [TYPE_W-1:0] type_buf [N];
  logic [W-1:0]      cs_first_dist, cs_second_dist, wb_first_dist, wb_second_dist;
  logic [TYPE_W-1:0] cs_first_type, cs_second_type, wb_first_type, wb_second_type;

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign bus.out_valid = (state == ST_OUTPUT);
  assign busy          = (state == ST_SORT) || (state == ST_OUTPUT);
  assign bus.out_last  = bus.out_valid && (out_idx == LAST_OUT);
  assign bus.out_dist  = bus.out_valid ? dist_buf[AW'(out_idx)] : '0;
  assign bus.out_type  = bus.out_valid ? type_buf[AW'(out_idx)] : '0;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_load = (load_idx == LAST_LOAD);
  assign last_pair = pass[0] ? (pair == LAST_PAIR_O) : (pair == LAST_PAIR_E);
  assign sort_done = (sort_tmr == '0);

  // Pair j of pass p starts at slot 2*j + p[0].
  assign left_idx  = AW'(pair + pair + CW'(pass[0]));
  assign right_idx = left_idx + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (in_fire) state_nx = ST_LOAD;
      ST_LOAD:   if (in_fire && last_load) state_nx = ST_SORT;
      ST_SORT:   if (sort_done) state_nx = ST_OUTPUT;
      ST_OUTPUT: if (out_fire && bus.out_last) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx <= '0;
      out_idx  <= '0;
      pass     <= '0;
      pair     <= '0;
      phase    <= 1'b0;
      sort_tmr <= '0;
      asc_q    <= 1'b1;
    end else begin
      if (in_fire) begin
        load_idx <= last_load ? '0 : load_idx + CW'(1);
        if (state == ST_IDLE) asc_q <= ascending;
        if (last_load) begin
          pass     <= '0;
          pair     <= '0;
          phase    <= 1'b0;
          sort_tmr <= TW'(SORT_CYC - 1);
        end
      end
      if (state == ST_SORT) begin
        phase <= ~phase;
        if (!sort_done) sort_tmr <= sort_tmr - TW'(1);
        if (phase) begin
          if (last_pair) begin
            pair <= '0;
            pass <= pass + CW'(1);
          end else begin
            pair <= pair + CW'(1);
          end
        end
        if (sort_done) out_idx <= '0;
      end
      if (out_fire) out_idx <= bus.out_last ? '0 : out_idx + CW'(1);
    end
  end

  cmp_swap #(.W(W), .TYPE_W(TYPE_W)) u_cmp_swap (
    .ascending   (asc_q),
    .a_dist      (dist_buf[left_idx]),
    .a_type      (type_buf[left_idx]),
    .b_dist      (dist_buf[right_idx]),
    .b_type      (type_buf[right_idx]),
    .first_dist  (cs_first_dist),
    .first_type  (cs_first_type),
    .second_dist (cs_second_dist),
    .second_type (cs_second_type)
  );

  // Phase 0 captures the compare result. Phase 1 writes both slots back.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      dist_buf[AW'(load_idx)] <= bus.in_dist;
      type_buf[AW'(load_idx)] <= bus.in_type;
    end else if (state == ST_SORT && phase) begin
      dist_buf[left_idx]  <= wb_first_dist;
      type_buf[left_idx]  <= wb_first_type;
      dist_buf[right_idx] <= wb_second_dist;
      type_buf[right_idx] <= wb_second_type;
    end
    if (state == ST_SORT && !phase) begin
      wb_first_dist  <= cs_first_dist;
      wb_first_type  <= cs_first_type;
      wb_second_dist <= cs_second_dist;
      wb_second_type <= cs_second_type;
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Two sorter instances with K=3 and K=8 share the load stream.
// Their outputs are compared against a stable insertion-sort reference.
module tb_sort_seq_ctrl;
  localparam int W       = 16;
  localparam int TYPE_W  = 3;
  localparam int N       = 8;
  localparam int KA      = 3;
  localparam int KB      = 8;
  localparam int EXP_LAT = 2 * (N / 2) * (N - 1) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ascending = 1'b1;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_dist = '0;
  logic [TYPE_W-1:0] in_type = '0;
  logic              rdy_a = 1'b0;
  logic              rdy_b = 1'b0;
  logic              busy_a, busy_b;
  int                n_checks = 0;
  int                n_pass = 0;
  logic [W-1:0]      bd [N];
  logic [TYPE_W-1:0] bt [N];
  logic [W-1:0]      md [N];
  logic [TYPE_W-1:0] mt [N];

  sort_seq_ctrl_if #(.W(W), .TYPE_W(TYPE_W)) bus_a ();
  sort_seq_ctrl_if #(.W(W), .TYPE_W(TYPE_W)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_dist   = in_dist;
  assign bus_a.in_type   = in_type;
  assign bus_a.out_ready = rdy_a;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_dist   = in_dist;
  assign bus_b.in_type   = in_type;
  assign bus_b.out_ready = rdy_b;

  sort_seq_ctrl #(.W(W), .TYPE_W(TYPE_W), .N(N), .K(KA)) dut_a (
    .clk(clk), .rst(rst), .ascending(ascending), .busy(busy_a), .bus(bus_a)
  );
  sort_seq_ctrl #(.W(W), .TYPE_W(TYPE_W), .N(N), .K(KB)) dut_b (
    .clk(clk), .rst(rst), .ascending(ascending), .busy(busy_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Stable insertion sort: equal distances keep load order in either direction.
  task automatic model_sort(input logic asc);
    logic [W-1:0]      kd;
    logic [TYPE_W-1:0] kt;
    int                j;
    for (int i = 0; i < N; i++) begin
      md[i] = bd[i];
      mt[i] = bt[i];
    end
    for (int i = 1; i < N; i++) begin
      kd = md[i];
      kt = mt[i];
      j  = i - 1;
      while (j >= 0 && (asc ? (md[j] > kd) : (md[j] < kd))) begin
        md[j+1] = md[j];
        mt[j+1] = mt[j];
        j--;
      end
      md[j+1] = kd;
      mt[j+1] = kt;
    end
  endtask

  function automatic logic pick_ready(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n >= 10);
    return 1'($urandom_range(1));
  endfunction

  task automatic load_batch(input int gap_pct, input logic flip);
    int   idx = 0;
    int   guard = 0;
    logic acc;
    while (idx < N && guard < 1000) begin
      acc = 1'b0;
      if (bus_a.in_ready && bus_b.in_ready && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_dist  = bd[idx];
        in_type  = bt[idx];
        acc      = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_dist  = W'($urandom);
        in_type  = TYPE_W'($urandom);
      end
      @(negedge clk);
      guard++;
      if (acc) begin
        idx++;
        if (flip && idx == 1) ascending = ~ascending;
      end
    end
    in_valid = 1'b0;
    check_val("load_count", idx, N);
  endtask

  task automatic collect_batch(input logic asc, input int rdy_mode);
    int   ia = 0, ib = 0, lat = 1, cyc = 0, st_a = 0, st_b = 0;
    logic seen = 1'b0, done_a = 1'b0, done_b = 1'b0;
    model_sort(asc);
    while (!(done_a && done_b) && cyc < 2000) begin
      if (!seen && (bus_a.out_valid || bus_b.out_valid)) begin
        seen = 1'b1;
        check_val("first_valid_lat", lat, EXP_LAT);
      end
      if (lat == 10) begin
        check_val("sort_flags_a", {bus_a.out_valid, bus_a.out_last, bus_a.in_ready, busy_a}, 4'b0001);
        check_val("sort_flags_b", {bus_b.out_valid, bus_b.out_last, bus_b.in_ready, busy_b}, 4'b0001);
        check_val("sort_zero_a", {bus_a.out_dist, bus_a.out_type}, 0);
      end
      if (done_a) check_val("a_after_last", bus_a.out_valid, 0);
      else if (bus_a.out_valid) begin
        check_val("a_dist", bus_a.out_dist, md[ia]);
        check_val("a_type", bus_a.out_type, mt[ia]);
        check_val("a_last", bus_a.out_last, ia == KA - 1);
        check_val("a_in_ready", bus_a.in_ready, 0);
        rdy_a = pick_ready(rdy_mode, st_a);
        st_a++;
        if (rdy_a) begin
          ia++;
          done_a = (ia == KA);
        end
      end else rdy_a = 1'($urandom_range(1));
      if (done_b) check_val("b_after_last", bus_b.out_valid, 0);
      else if (bus_b.out_valid) begin
        check_val("b_dist", bus_b.out_dist, md[ib]);
        check_val("b_type", bus_b.out_type, mt[ib]);
        check_val("b_last", bus_b.out_last, ib == KB - 1);
        check_val("b_busy", busy_b, 1);
        rdy_b = pick_ready(rdy_mode, st_b);
        st_b++;
        if (rdy_b) begin
          ib++;
          done_b = (ib == KB);
        end
      end else rdy_b = 1'($urandom_range(1));
      @(negedge clk);
      lat++;
      cyc++;
    end
    check_val("a_count", ia, KA);
    check_val("b_count", ib, KB);
    check_val("idle_after", {bus_a.out_valid, bus_b.out_valid, busy_a, busy_b}, 0);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  task automatic set_types_seq();
    for (int i = 0; i < N; i++) bt[i] = TYPE_W'(i);
  endtask

  task automatic set_random_batch(input int b);
    for (int i = 0; i < N; i++) begin
      bd[i] = (b % 2 == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
      bt[i] = TYPE_W'($urandom_range(0, 7));
    end
  endtask

  initial begin
    logic asc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {busy_a, busy_b}, 0);
    check_val("rst_out_valid", {bus_a.out_valid, bus_a.out_last, bus_b.out_valid, bus_b.out_last}, 0);
    check_val("rst_out_data", {bus_a.out_dist, bus_a.out_type}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", {bus_a.in_ready, bus_b.in_ready}, 2'b11);

    // Scenario 1: ascending.
    bd = '{50, 10, 70, 30, 20, 80, 60, 40};
    set_types_seq();
    ascending = 1'b1;
    load_batch(0, 1'b0);
    collect_batch(1'b1, 0);

    // Scenario 2: descending.
    ascending = 1'b0;
    load_batch(0, 1'b0);
    collect_batch(1'b0, 0);

    // Scenario 3: ties.
    bd = '{5, 5, 5, 1, 1, 9, 9, 9};
    ascending = 1'b1;
    load_batch(0, 1'b0);
    collect_batch(1'b1, 0);

    // Scenario 4: output stalled for 10 cycles.
    bd = '{50, 10, 70, 30, 20, 80, 60, 40};
    ascending = 1'b1;
    load_batch(0, 1'b0);
    collect_batch(1'b1, 1);

    // Scenario 5: reset during sort cycle 20, then a fresh batch.
    set_random_batch(1);
    ascending = 1'b0;
    load_batch(0, 1'b0);
    repeat (19) @(negedge clk);
    check_val("pre_rst_busy", {busy_a, busy_b}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_busy", {busy_a, busy_b}, 0);
    check_val("mid_rst_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", {bus_a.in_ready, bus_b.in_ready}, 2'b11);
    set_random_batch(2);
    ascending = 1'b1;
    load_batch(30, 1'b0);
    collect_batch(1'b1, 2);

    // Scenario 6 and random batches: irregular valid, late direction flips, random ready.
    for (int b = 0; b < 14; b++) begin
      set_random_batch(b);
      asc = 1'($urandom_range(1));
      ascending = asc;
      load_batch(40, 1'b1);
      collect_batch(asc, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
